// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix memory responder: default sizes,
// operand bank selectors and the run-tracking state encoding.
package matrix_pkg;

  localparam int N_DEF  = 2;
  localparam int W_DEF  = 8;
  localparam int AW_DEF = 32;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/operand_bank.sv
// Single-write operand store with a registered read address; out-of-range
// read addresses are clamped to entry 0 and reported through rd_oob.
module operand_bank #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = 32,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_addr,
  input  logic signed [W-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  input  logic                rd_en,
  output logic signed [W-1:0] rd_data,
  output logic                rd_oob
);

  logic signed [W-1:0] mem_reg [DEPTH];
  logic [IW-1:0]       addr_reg;
  logic                rd_ok;

  assign rd_ok  = rd_addr < AW'(DEPTH);
  assign rd_oob = rd_en && !rd_ok;

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
  end

  // The address is captured every cycle; rd_en only qualifies error reporting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) addr_reg <= '0;
    else        addr_reg <= rd_ok ? rd_addr[IW-1:0] : '0;
  end

  assign rd_data = mem_reg[addr_reg];

endmodule

// File: rtl/matrix_mem_responder.sv
// Memory-side responder for the matrix control FSM: A/B operand banks, a
// clearable C result bank with a write bitmap, a host port and run tracking.
module matrix_mem_responder
  import matrix_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_wr_en,
  input  logic                  host_sel,
  input  logic [AW-1:0]         host_addr,
  input  logic signed [W-1:0]   host_wdata,
  input  logic                  host_rd_en,
  input  logic [AW-1:0]         host_rd_addr,
  output logic signed [2*W-1:0] host_rd_data,
  output logic                  host_rd_valid,
  input  logic                  run_start,
  input  logic [AW-1:0]         read_addr_A,
  input  logic                  read_en_A,
  output logic signed [W-1:0]   A_out,
  input  logic [AW-1:0]         read_addr_B,
  input  logic                  read_en_B,
  output logic signed [W-1:0]   B_out,
  input  logic [AW-1:0]         write_addr_C,
  input  logic                  write_en_C,
  input  logic signed [2*W-1:0] C_in,
  output logic [AW-1:0]         c_write_count,
  output logic                  run_done,
  output logic                  oob_error,
  output logic                  host_conflict
);

  localparam int              DEPTH   = N * N;
  localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   DEPTH_A = AW'(DEPTH);

  state_t state_reg, state_next;

  logic                  host_addr_ok, host_rd_ok, c_addr_ok;
  logic                  host_wr_ok, c_wr_ok, c_first, last_write;
  logic                  a_oob, b_oob, oob_set;
  logic [IW-1:0]         c_idx;
  logic [DEPTH-1:0]      bitmap;
  logic signed [2*W-1:0] c_bank [DEPTH];

  assign host_addr_ok = host_addr < DEPTH_A;
  assign host_rd_ok   = host_rd_addr < DEPTH_A;
  assign c_addr_ok    = write_addr_C < DEPTH_A;
  assign c_idx        = write_addr_C[IW-1:0];

  assign host_wr_ok = host_wr_en && (state_reg != RUN) && host_addr_ok;
  // A run_start in the same cycle wins over the C write.
  assign c_wr_ok    = write_en_C && (state_reg == RUN) && !run_start && c_addr_ok;
  assign c_first    = c_wr_ok && !bitmap[c_idx];
  assign last_write = c_first && (c_write_count == DEPTH_A - AW'(1));

  operand_bank #(.DEPTH(DEPTH), .W(W), .AW(AW), .IW(IW)) u_bank_a (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (host_wr_ok && (host_sel == BANK_A)),
    .wr_addr (host_addr[IW-1:0]),
    .wr_data (host_wdata),
    .rd_addr (read_addr_A),
    .rd_en   (read_en_A),
    .rd_data (A_out),
    .rd_oob  (a_oob)
  );

  operand_bank #(.DEPTH(DEPTH), .W(W), .AW(AW), .IW(IW)) u_bank_b (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (host_wr_ok && (host_sel == BANK_B)),
    .wr_addr (host_addr[IW-1:0]),
    .wr_data (host_wdata),
    .rd_addr (read_addr_B),
    .rd_en   (read_en_B),
    .rd_data (B_out),
    .rd_oob  (b_oob)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (run_start) state_next = RUN;
      RUN:     if (run_start) state_next = RUN;
               else if (last_write) state_next = DONE;
      DONE:    if (run_start) state_next = RUN;
               else if (host_wr_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // C entries are individual registers so run_start can clear them in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_c_entry
      logic                  written_reg;
      logic signed [2*W-1:0] data_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             written_reg <= 1'b0;
        else if (run_start)                     written_reg <= 1'b0;
        else if (c_wr_ok && c_idx == IW'(gi))   written_reg <= 1'b1;
      end

      always_ff @(posedge clk) begin
        if (run_start)                          data_reg <= '0;
        else if (c_wr_ok && c_idx == IW'(gi))   data_reg <= C_in;
      end

      assign bitmap[gi] = written_reg;
      assign c_bank[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_write_count <= '0;
      run_done      <= 1'b0;
    end else if (run_start) begin
      c_write_count <= '0;
      run_done      <= 1'b0;
    end else if (c_first) begin
      c_write_count <= c_write_count + AW'(1);
      if (last_write) run_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rd_data  <= '0;
      host_rd_valid <= 1'b0;
    end else begin
      host_rd_valid <= host_rd_en;
      if (host_rd_en) host_rd_data <= host_rd_ok ? c_bank[host_rd_addr[IW-1:0]] : '0;
    end
  end

  assign oob_set = a_oob || b_oob
                || (host_wr_en && (state_reg != RUN) && !host_addr_ok)
                || (write_en_C && (state_reg == RUN) && !c_addr_ok)
                || (host_rd_en && !host_rd_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_error     <= 1'b0;
      host_conflict <= 1'b0;
    end else begin
      if (oob_set) oob_error <= 1'b1;
      if (host_wr_en && (state_reg == RUN)) host_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Self-checking bench for matrix_mem_responder: directed scenarios followed by
// randomized operations, all checked against an array-based behavioural model.
module tb_matrix_mem_responder;

  localparam int N = 2, W = 8, AW = 32, DEPTH = N * N;
  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  host_wr_en, host_sel, host_rd_en, run_start;
  logic [AW-1:0]         host_addr, host_rd_addr;
  logic signed [W-1:0]   host_wdata;
  logic signed [2*W-1:0] host_rd_data;
  logic                  host_rd_valid;
  logic [AW-1:0]         read_addr_A, read_addr_B, write_addr_C;
  logic                  read_en_A, read_en_B, write_en_C;
  logic signed [W-1:0]   A_out, B_out;
  logic signed [2*W-1:0] C_in;
  logic [AW-1:0]         c_write_count;
  logic                  run_done, oob_error, host_conflict;

  always #5 clk = ~clk;

  matrix_mem_responder #(.N(N), .W(W), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .host_wr_en(host_wr_en), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr),
    .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid), .run_start(run_start),
    .read_addr_A(read_addr_A), .read_en_A(read_en_A), .A_out(A_out),
    .read_addr_B(read_addr_B), .read_en_B(read_en_B), .B_out(B_out),
    .write_addr_C(write_addr_C), .write_en_C(write_en_C), .C_in(C_in),
    .c_write_count(c_write_count), .run_done(run_done),
    .oob_error(oob_error), .host_conflict(host_conflict)
  );

  // Behavioural model: plain arrays plus run bookkeeping.
  logic signed [W-1:0]   m_a [DEPTH];
  logic signed [W-1:0]   m_b [DEPTH];
  logic signed [2*W-1:0] m_c [DEPTH];
  bit                    m_wr [DEPTH];
  int                    m_count, m_phase;
  bit                    m_done, m_oob, m_conf;
  int                    n_vec = 0, n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_wr_en = 0; host_sel = 0; host_addr = '0; host_wdata = '0;
    host_rd_en = 0; host_rd_addr = '0; run_start = 0;
    read_addr_A = '0; read_en_A = 0; read_addr_B = '0; read_en_B = 0;
    write_addr_C = '0; write_en_C = 0; C_in = '0;
  endtask

  task automatic model_clear_run();
    for (int i = 0; i < DEPTH; i++) begin m_c[i] = '0; m_wr[i] = 0; end
    m_count = 0; m_done = 0; m_phase = P_RUN;
  endtask

  task automatic do_host_write(input logic sel, input int addr, input logic signed [W-1:0] data);
    host_wr_en = 1; host_sel = sel; host_addr = addr; host_wdata = data;
    tick();
    host_wr_en = 0;
    $display("host_wr  bank=%0d addr=%0d data=%0d", sel, addr, data);
    if (m_phase == P_RUN) m_conf = 1;
    else begin
      if (addr >= DEPTH) m_oob = 1;
      else if (sel) m_b[addr] = data;
      else m_a[addr] = data;
      m_phase = P_IDLE;
    end
    n_vec++; if (host_conflict !== m_conf) begin n_err++;
      $display("FAIL host_conflict: got %0b expected %0b", host_conflict, m_conf); end
    n_vec++; if (oob_error !== m_oob) begin n_err++;
      $display("FAIL oob_after_host_wr: got %0b expected %0b", oob_error, m_oob); end
  endtask

  task automatic do_run_start();
    run_start = 1;
    tick();
    run_start = 0;
    $display("run_start");
    model_clear_run();
    n_vec++; if (c_write_count !== 0 || run_done !== 1'b0) begin n_err++;
      $display("FAIL run_start_clear: got count=%0d done=%0b expected 0/0", c_write_count, run_done); end
    n_vec++; if (oob_error !== m_oob) begin n_err++;
      $display("FAIL oob_sticky: got %0b expected %0b", oob_error, m_oob); end
  endtask

  task automatic model_c_write(input int addr, input logic signed [2*W-1:0] data);
    if (m_phase != P_RUN) return;
    if (addr >= DEPTH) begin m_oob = 1; return; end
    m_c[addr] = data;
    if (!m_wr[addr]) begin
      m_wr[addr] = 1; m_count++;
      if (m_count == DEPTH) begin m_done = 1; m_phase = P_DONE; end
    end
  endtask

  task automatic do_c_write(input int addr, input logic signed [2*W-1:0] data);
    write_en_C = 1; write_addr_C = addr; C_in = data;
    tick();
    write_en_C = 0;
    $display("c_write  addr=%0d data=%0d", addr, data);
    model_c_write(addr, data);
    n_vec++; if (c_write_count !== AW'(m_count)) begin n_err++;
      $display("FAIL c_write_count: got %0d expected %0d", c_write_count, m_count); end
    n_vec++; if (run_done !== m_done) begin n_err++;
      $display("FAIL run_done: got %0b expected %0b", run_done, m_done); end
    n_vec++; if (oob_error !== m_oob) begin n_err++;
      $display("FAIL oob_after_c_wr: got %0b expected %0b", oob_error, m_oob); end
  endtask

  task automatic do_host_read(input int addr);
    logic signed [2*W-1:0] exp_d;
    host_rd_en = 1; host_rd_addr = addr;
    tick();
    host_rd_en = 0;
    exp_d = (addr < DEPTH) ? m_c[addr] : '0;
    if (addr >= DEPTH) m_oob = 1;
    $display("host_rd  addr=%0d data=%0d", addr, host_rd_data);
    n_vec++; if (host_rd_valid !== 1'b1 || host_rd_data !== exp_d) begin n_err++;
      $display("FAIL host_rd_data: got valid=%0b data=%0d expected valid=1 data=%0d", host_rd_valid, host_rd_data, exp_d); end
    n_vec++; if (oob_error !== m_oob) begin n_err++;
      $display("FAIL oob_after_host_rd: got %0b expected %0b", oob_error, m_oob); end
    tick();
    n_vec++; if (host_rd_valid !== 1'b0) begin n_err++;
      $display("FAIL host_rd_valid_pulse: got %0b expected 0", host_rd_valid); end
  endtask

  task automatic do_read_ab(input int aa, input bit ea, input int ba, input bit eb);
    logic signed [W-1:0] exp_a, exp_b;
    read_addr_A = aa; read_en_A = ea; read_addr_B = ba; read_en_B = eb;
    tick();
    read_addr_A = '0; read_en_A = 0; read_addr_B = '0; read_en_B = 0;
    exp_a = m_a[(aa < DEPTH) ? aa : 0];
    exp_b = m_b[(ba < DEPTH) ? ba : 0];
    if ((ea && aa >= DEPTH) || (eb && ba >= DEPTH)) m_oob = 1;
    $display("ab_read  a_addr=%0d a=%0d b_addr=%0d b=%0d", aa, A_out, ba, B_out);
    n_vec++; if (A_out !== exp_a) begin n_err++;
      $display("FAIL A_out: got %0d expected %0d", A_out, exp_a); end
    n_vec++; if (B_out !== exp_b) begin n_err++;
      $display("FAIL B_out: got %0d expected %0d", B_out, exp_b); end
    n_vec++; if (oob_error !== m_oob) begin n_err++;
      $display("FAIL oob_after_ab_rd: got %0b expected %0b", oob_error, m_oob); end
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    tick(); tick();
    n_vec++; if (host_rd_data !== '0 || host_rd_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_host_rd: got data=%0d valid=%0b expected 0/0", host_rd_data, host_rd_valid); end
    n_vec++; if (c_write_count !== '0 || run_done !== 1'b0) begin n_err++;
      $display("FAIL reset_count: got count=%0d done=%0b expected 0/0", c_write_count, run_done); end
    n_vec++; if (oob_error !== 1'b0 || host_conflict !== 1'b0) begin n_err++;
      $display("FAIL reset_flags: got oob=%0b conf=%0b expected 0/0", oob_error, host_conflict); end
    reset = 1;
    m_count = 0; m_done = 0; m_oob = 0; m_conf = 0; m_phase = P_IDLE;
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    tick();
  endtask

  task automatic test_load_and_read();
    logic signed [W-1:0] av [DEPTH];
    logic signed [W-1:0] bv [DEPTH];
    av = '{8'sd7, 8'sd8, 8'sd0, 8'sd9};
    bv = '{8'sd3, 8'sd5, 8'sd4, 8'sd2};
    for (int i = 0; i < DEPTH; i++) do_host_write(1'b0, i, av[i]);
    for (int i = 0; i < DEPTH; i++) do_host_write(1'b1, i, bv[i]);
    do_read_ab(1, 1, 3, 1);
    do_read_ab(3, 1, 0, 1);
  endtask

  task automatic test_run();
    do_run_start();
    do_c_write(0, 16'sd53);
    do_c_write(1, 16'sd51);
    do_c_write(2, 16'sd36);
    do_c_write(3, 16'sd18);
    for (int i = 0; i < DEPTH; i++) do_host_read(i);
  endtask

  task automatic test_repeat_write();
    do_run_start();
    do_c_write(2, 16'sd36);
    do_c_write(2, 16'sd36);
    do_c_write(2, -16'sd5);
    do_host_read(2);
  endtask

  task automatic test_oob();
    do_read_ab(7, 1, 1, 0);
    do_run_start();
    do_host_read(9);
  endtask

  task automatic test_conflict();
    do_host_write(1'b0, 0, 8'sd99);
    do_read_ab(0, 1, 0, 1);
    for (int i = 0; i < DEPTH; i++) do_c_write(i, 16'(i * 10 + 1));
    do_host_write(1'b0, 0, -8'sd12);
    do_read_ab(0, 1, 0, 0);
    do_c_write(1, 16'sd500);
    do_host_read(1);
    do_host_write(1'b1, 1, 8'sd33);
    do_read_ab(0, 0, 1, 1);
  endtask

  task automatic test_same_cycle();
    host_wr_en = 1; host_sel = 1'b0; host_addr = 2; host_wdata = 8'sd77;
    read_addr_A = 2; read_en_A = 1;
    tick();
    idle_inputs();
    m_a[2] = 8'sd77;
    $display("host_wr+rd bank=0 addr=2 data=77 A_out=%0d", A_out);
    n_vec++; if (A_out !== 8'sd77) begin n_err++;
      $display("FAIL wr_rd_same_entry: got %0d expected 77", A_out); end
    do_run_start();
    do_c_write(1, 16'sd100);
    write_en_C = 1; write_addr_C = 1; C_in = -16'sd200;
    host_rd_en = 1; host_rd_addr = 1;
    tick();
    idle_inputs();
    $display("c_write+host_rd addr=1 data=-200 rd=%0d", host_rd_data);
    n_vec++; if (host_rd_data !== 16'sd100) begin n_err++;
      $display("FAIL c_rd_old_value: got %0d expected 100", host_rd_data); end
    model_c_write(1, -16'sd200);
    do_host_read(1);
    run_start = 1; write_en_C = 1; write_addr_C = 0; C_in = 16'sd42;
    tick();
    idle_inputs();
    model_clear_run();
    $display("run_start+c_write addr=0 data=42");
    n_vec++; if (c_write_count !== '0) begin n_err++;
      $display("FAIL clear_wins_count: got %0d expected 0", c_write_count); end
    do_host_read(0);
  endtask

  task automatic test_reset_midrun();
    do_run_start();
    do_c_write(0, 16'sd11);
    do_c_write(1, 16'sd22);
    do_host_read(1);
    do_host_write(1'b0, 0, 8'sd1);
    do_host_read(6);
    #2 reset = 0;
    #1;
    $display("reset asserted mid-run");
    n_vec++; if (c_write_count !== '0 || run_done !== 1'b0) begin n_err++;
      $display("FAIL midrun_reset_count: got count=%0d done=%0b expected 0/0", c_write_count, run_done); end
    n_vec++; if (oob_error !== 1'b0 || host_conflict !== 1'b0) begin n_err++;
      $display("FAIL midrun_reset_flags: got oob=%0b conf=%0b expected 0/0", oob_error, host_conflict); end
    n_vec++; if (host_rd_data !== '0 || host_rd_valid !== 1'b0) begin n_err++;
      $display("FAIL midrun_reset_rd: got data=%0d valid=%0b expected 0/0", host_rd_data, host_rd_valid); end
    tick();
    reset = 1;
    m_count = 0; m_done = 0; m_oob = 0; m_conf = 0; m_phase = P_IDLE;
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    do_run_start();
    do_c_write(2, 16'sd5);
  endtask

  task automatic test_random();
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0: do_host_write(1'($urandom_range(0, 1)), $urandom_range(0, 5), W'($urandom));
        1: if ($urandom_range(0, 3) == 0) do_run_start();
           else do_c_write($urandom_range(0, 5), 16'($urandom));
        2, 3: do_c_write($urandom_range(0, 5), 16'($urandom));
        4: do_host_read($urandom_range(0, 5));
        default: do_read_ab($urandom_range(0, 5), 1'($urandom_range(0, 1)),
                            $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_and_read();
    test_run();
    test_repeat_write();
    test_oob();
    test_conflict();
    test_same_cycle();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_mem_responder.md
Name: matrix_mem_responder

Overview:
- Memory-side responder for the top control FSM's operand and result ports. It serves A/B read requests with one-cycle latency and captures C write-backs.
- Provides a host port for loading A/B and reading back C, and tracks run completion.
- Replaces the behavioural A/B/C arrays currently living in the benches. It sits between the host and the top control FSM, so the same memory model is used in simulation and on FPGA.

Parameters:
- N, 2, matrix dimension; each bank holds N*N entries.
- W, 8, operand width; C entries are 2*W wide.
- AW, 32, address width on all ports.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- host_wr_en  in  1  host operand write strobe
- host_sel  in  1  0 = bank A, 1 = bank B
- host_addr  in  AW  host write address
- host_wdata  in  W  signed operand data
- host_rd_en  in  1  host C read strobe
- host_rd_addr  in  AW  host C read address
- host_rd_data  out  2*W  signed C data
- host_rd_valid  out  1  host_rd_data valid (one-cycle pulse)
- run_start  in  1  arm a run; clears C bank and write bitmap
- read_addr_A, read_en_A  in  AW, 1  FSM A read request
- A_out  out  W  signed A data
- read_addr_B, read_en_B  in  AW, 1  FSM B read request
- B_out  out  W  signed B data
- write_addr_C, write_en_C  in  AW, 1  FSM C write request
- C_in  in  2*W  signed C data
- c_write_count  out  AW  number of distinct C entries written this run
- run_done  out  1  all N*N C entries written
- oob_error  out  1  sticky flag: out-of-range access seen
- host_conflict  out  1  sticky flag: host operand write during RUN

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; A/B address registers = 0; host_rd_data = 0; host_rd_valid = 0.
  - c_write_count = 0; run_done = 0; oob_error = 0; host_conflict = 0; bitmap cleared.
  - Memory contents are not reset.
- States:
  - IDLE: host loads operands.
  - IDLE -> RUN on run_start.
  - RUN -> DONE when c_write_count reaches N*N.
  - DONE -> RUN on run_start.
  - DONE -> IDLE on a host_wr_en.
  - run_start in RUN restarts the run: C bank and bitmap are cleared, count = 0, state stays RUN.
- A/B reads:
  - Every posedge, the address register loads read_addr_X if it is < N*N, else 0. Read_en_X does not gate this; it qualifies error reporting only.
  - X_out = bank_X[addr_reg] combinationally, so data is valid one cycle after the address.
  - An out-of-range address while read_en_X = 1 sets oob_error.
  - Reads are served in every state.
- Host operand writes:
  - Accepted in IDLE and DONE only; host_addr >= N*N is dropped and sets oob_error.
  - In RUN the write is dropped and sets host_conflict.
  - A write and a read to the same entry in one cycle: the new data is visible on the next cycle's X_out.
- C writes:
  - Accepted only in RUN with write_addr_C < N*N; otherwise dropped.
  - An out-of-range address sets oob_error; a write outside RUN is ignored silently.
  - First write to an entry sets its bitmap bit and increments c_write_count.
  - Repeat writes overwrite the data without incrementing the count.
  - run_done rises the cycle after the N*N-th distinct write and holds until the next run_start or reset.
- Host C reads:
  - host_rd_en: the next cycle gives host_rd_data = C[addr] (0 if out of range, which also sets oob_error) with host_rd_valid = 1.
  - Allowed in any state.
  - A same-cycle C write to the same address returns the old value.
- run_start clears: C bank to 0, bitmap, c_write_count and run_done. Sticky error flags are cleared only by reset.
- Simultaneous run_start and write_en_C: the clear wins and the write is dropped.
- All arithmetic is unsigned on addresses. Data is stored sign-preserving with no width conversion.

Decomposition:
- Shared package (matrix_pkg): state enum (IDLE, RUN, DONE), N/W defaults, bank-select constants (BANK_A = 0, BANK_B = 1).
- One natural sub-module: operand_bank (single-write, registered-address read, out-of-range clamp), instantiated for A and for B.
- The C bank and bitmap stay inline.

Test Plan:
- Load A = {7, 8, 0, 9}, B = {3, 5, 4, 2}; drive read_addr_A = 1 -> A_out = 8 on the next cycle; read_addr_B = 3 -> B_out = 2.
- run_start, then C writes {0: 53, 1: 51, 2: 36, 3: 18} -> c_write_count steps 1..4; run_done = 1 the cycle after the 4th write; host reads return 53/51/36/18 with host_rd_valid one cycle after each request.
- In RUN: write C[2] = 36 twice, then C[2] = -5 -> count = 1, C[2] = -5.
- read_addr_A = 7 with read_en_A = 1 -> A_out = A[0] = 7 and oob_error = 1; it stays set across run_start.
- host_wr_en during RUN -> bank unchanged, host_conflict = 1; host write in DONE -> accepted, state = IDLE.
- Assert reset mid-run after 2 C writes -> all outputs at reset values immediately; a new run_start starts count from 0 and run_done = 0.
